// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter for the single data-memory port: LSU (port 0) and debug/DMA (port 1).
// One transaction in flight, round-robin on contention, watchdog error termination.
module dmem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lsu_req,
    input  logic                lsu_we,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [DATA_W/8-1:0] lsu_be,
    input  logic [DATA_W-1:0]   lsu_wdata,
    output logic                lsu_gnt,
    output logic                lsu_rvalid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_err,
    input  logic                dbg_req,
    input  logic                dbg_we,
    input  logic [ADDR_W-1:0]   dbg_addr,
    input  logic [DATA_W/8-1:0] dbg_be,
    input  logic [DATA_W-1:0]   dbg_wdata,
    output logic                dbg_gnt,
    output logic                dbg_rvalid,
    output logic [DATA_W-1:0]   dbg_rdata,
    output logic                dbg_err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);
    localparam int BE_W = DATA_W / 8;
    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_owner;
    logic              r_ptr;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [BE_W-1:0]   r_be;
    logic [DATA_W-1:0] r_wdata;
    logic [WD_W-1:0]   r_wd;

    logic              w_any_req;
    logic              w_win;
    logic              w_timeout;
    logic              w_gnt;
    logic              w_rvalid;
    logic              w_err;
    logic              w_done;
    logic              w_mem_req;
    logic [DATA_W-1:0] w_rdata;

    assign w_any_req = lsu_req | dbg_req;
    // Contention goes to the pointer; a lone requester always wins.
    assign w_win     = (lsu_req & dbg_req) ? r_ptr : dbg_req;
    assign w_timeout = (TIMEOUT != 0) && (r_state != ST_IDLE) && (r_wd == WD_W'(TIMEOUT));

    always_comb begin
        w_state_next = r_state;
        w_gnt        = 1'b0;
        w_rvalid     = 1'b0;
        w_err        = 1'b0;
        w_done       = 1'b0;
        w_mem_req    = 1'b0;
        w_rdata      = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_any_req) w_state_next = ST_REQ;
            end
            ST_REQ: begin
                if (w_timeout) begin
                    w_gnt        = 1'b1;
                    w_rvalid     = 1'b1;
                    w_err        = 1'b1;
                    w_done       = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_mem_req = 1'b1;
                    if (mem_gnt) begin
                        w_gnt        = 1'b1;
                        w_state_next = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (w_timeout) begin
                    w_rvalid     = 1'b1;
                    w_err        = 1'b1;
                    w_done       = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (mem_rvalid) begin
                    w_rvalid     = 1'b1;
                    w_rdata      = mem_rdata;
                    w_done       = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_owner <= 1'b0;
            r_ptr   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_wd    <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_IDLE && w_any_req) begin
                r_owner <= w_win;
                r_we    <= w_win ? dbg_we    : lsu_we;
                r_addr  <= w_win ? dbg_addr  : lsu_addr;
                r_be    <= w_win ? dbg_be    : lsu_be;
                r_wdata <= w_win ? dbg_wdata : lsu_wdata;
                r_wd    <= '0;
            end else if (r_state != ST_IDLE && r_wd != WD_W'(TIMEOUT)) begin
                r_wd <= r_wd + WD_W'(1);
            end
            if (w_done) r_ptr <= ~r_owner;
        end
    end

    // Steer the shared response onto the owner; the other port sees zeros.
    logic [1:0]        w_port_gnt;
    logic [1:0]        w_port_rvalid;
    logic [1:0]        w_port_err;
    logic [DATA_W-1:0] w_port_rdata [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic w_sel;
        assign w_sel             = (gi == 0) ? ~r_owner : r_owner;
        assign w_port_gnt[gi]    = w_gnt & w_sel;
        assign w_port_rvalid[gi] = w_rvalid & w_sel;
        assign w_port_err[gi]    = w_err & w_sel;
        assign w_port_rdata[gi]  = w_sel ? w_rdata : '0;
    end

    assign lsu_gnt    = w_port_gnt[0];
    assign lsu_rvalid = w_port_rvalid[0];
    assign lsu_err    = w_port_err[0];
    assign lsu_rdata  = w_port_rdata[0];
    assign dbg_gnt    = w_port_gnt[1];
    assign dbg_rvalid = w_port_rvalid[1];
    assign dbg_err    = w_port_err[1];
    assign dbg_rdata  = w_port_rdata[1];

    assign mem_req   = w_mem_req;
    assign mem_we    = w_mem_req & r_we;
    assign mem_addr  = w_mem_req ? r_addr  : '0;
    assign mem_be    = w_mem_req ? r_be    : '0;
    assign mem_wdata = w_mem_req ? r_wdata : '0;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: transactions are planned (grant delay, response delay) and the
// expected per-cycle outputs follow from that plan, the round-robin rule and the watchdog limit.
module tb_dmem_port_arbiter;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lsu_req, lsu_we, dbg_req, dbg_we;
    logic [31:0] lsu_addr, lsu_wdata, dbg_addr, dbg_wdata;
    logic [3:0]  lsu_be, dbg_be;
    logic        lsu_gnt, lsu_rvalid, lsu_err, dbg_gnt, dbg_rvalid, dbg_err;
    logic [31:0] lsu_rdata, dbg_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic [140:0] all_out;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_be(lsu_be),
        .lsu_wdata(lsu_wdata), .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid),
        .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_be(dbg_be),
        .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
        .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    assign all_out = {lsu_gnt, lsu_rvalid, lsu_rdata, lsu_err, dbg_gnt, dbg_rvalid, dbg_rdata,
                      dbg_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata, busy};

    int n_vec = 0;
    int n_err = 0;
    int ptr_m = 0;
    logic        req_m  [2];
    logic        we_m   [2];
    logic [31:0] addr_m [2];
    logic [3:0]  be_m   [2];
    logic [31:0] wd_m   [2];

    task automatic drive();
        lsu_req = req_m[0]; lsu_we = we_m[0]; lsu_addr = addr_m[0]; lsu_be = be_m[0]; lsu_wdata = wd_m[0];
        dbg_req = req_m[1]; dbg_we = we_m[1]; dbg_addr = addr_m[1]; dbg_be = be_m[1]; dbg_wdata = wd_m[1];
    endtask

    task automatic set_port(input int p, input logic we, input logic [31:0] a,
                            input logic [3:0] be, input logic [31:0] wd);
        req_m[p] = 1'b1; we_m[p] = we; addr_m[p] = a; be_m[p] = be; wd_m[p] = wd;
    endtask

    task automatic set_random(input int p);
        set_port(p, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, 4'($urandom), $urandom);
    endtask

    // One transaction from the IDLE cycle to completion. g = REQ cycles before mem_gnt,
    // r = RESP cycles before mem_rvalid; anything reaching TO cycles ends in a watchdog error.
    task automatic run_txn(input int g, input int r, input logic [31:0] rdv);
        int w;
        bit granted, done, exp_to, exp_gnt, exp_rv, exp_mreq;
        logic [1:0]  eg, erv, eerr;
        logic [31:0] erd;
        drive();
        mem_gnt = 1'($urandom_range(0, 1)); mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = rdv;
        #1;
        n_vec++;
        if (busy !== 1'b0 || mem_req !== 1'b0 || {dbg_gnt, lsu_gnt, dbg_rvalid, lsu_rvalid} !== 4'b0) begin
            n_err++;
            $display("FAIL idle: busy=%b mem_req=%b gnt=%b%b rvalid=%b%b, required all 0",
                     busy, mem_req, dbg_gnt, lsu_gnt, dbg_rvalid, lsu_rvalid);
        end
        w = (req_m[0] && req_m[1]) ? ptr_m : (req_m[1] ? 1 : 0);
        $display("txn owner=%s g=%0d r=%0d we=%b addr=%h be=%b", (w == 1) ? "dbg" : "lsu",
                 g, r, we_m[w], addr_m[w], be_m[w]);
        @(negedge clk);
        granted = 0; done = 0;
        for (int i = 0; i <= TO && !done; i++) begin
            exp_to = (i == TO);
            if (!granted) begin
                mem_gnt = (i == g) && (g < TO);
                mem_rvalid = 1'($urandom_range(0, 1));
            end else begin
                mem_gnt = 1'($urandom_range(0, 1));
                mem_rvalid = (i == g + 1 + r) && (g + 1 + r < TO);
            end
            #1;
            exp_gnt  = !granted && ((i == g && g < TO) || exp_to);
            exp_rv   = exp_to || (granted && i == g + 1 + r && g + 1 + r < TO);
            exp_mreq = !granted && !exp_to;
            erd  = (exp_rv && !exp_to) ? rdv : 32'h0;
            eg   = exp_gnt ? ((w == 1) ? 2'b10 : 2'b01) : 2'b00;
            erv  = exp_rv  ? ((w == 1) ? 2'b10 : 2'b01) : 2'b00;
            eerr = exp_to  ? ((w == 1) ? 2'b10 : 2'b01) : 2'b00;
            n_vec++;
            if ({dbg_gnt, lsu_gnt} !== eg) begin
                n_err++; $display("FAIL gnt cyc%0d: {dbg,lsu}=%b required %b", i, {dbg_gnt, lsu_gnt}, eg);
            end
            n_vec++;
            if ({dbg_rvalid, lsu_rvalid} !== erv) begin
                n_err++; $display("FAIL rvalid cyc%0d: {dbg,lsu}=%b required %b", i, {dbg_rvalid, lsu_rvalid}, erv);
            end
            n_vec++;
            if ({dbg_err, lsu_err} !== eerr) begin
                n_err++; $display("FAIL err cyc%0d: {dbg,lsu}=%b required %b", i, {dbg_err, lsu_err}, eerr);
            end
            n_vec++;
            if (lsu_rdata !== ((w == 0) ? erd : 32'h0) || dbg_rdata !== ((w == 1) ? erd : 32'h0)) begin
                n_err++; $display("FAIL rdata cyc%0d: lsu=%h dbg=%h required %h on owner, 0 elsewhere",
                                  i, lsu_rdata, dbg_rdata, erd);
            end
            n_vec++;
            if (mem_req !== exp_mreq || busy !== 1'b1) begin
                n_err++; $display("FAIL mem_req cyc%0d: mem_req=%b busy=%b required %b 1", i, mem_req, busy, exp_mreq);
            end
            if (exp_mreq) begin
                n_vec++;
                if ({mem_we, mem_addr, mem_be, mem_wdata} !== {we_m[w], addr_m[w], be_m[w], wd_m[w]}) begin
                    n_err++; $display("FAIL mem_fields cyc%0d: we=%b addr=%h be=%b wd=%h required %b %h %b %h",
                                      i, mem_we, mem_addr, mem_be, mem_wdata, we_m[w], addr_m[w], be_m[w], wd_m[w]);
                end
            end
            if (exp_gnt) granted = 1;
            if (exp_rv) done = 1;
            @(negedge clk);
            if (exp_gnt) begin
                req_m[w] = 1'b0;
                drive();
            end
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        ptr_m = 1 - w;
    endtask

    task automatic drain();
        while (req_m[0] || req_m[1]) run_txn(0, 0, $urandom);
    endtask

    task automatic test_reset();
        set_port(0, 1'b0, 32'h40, 4'hF, 32'h1111_0000);
        set_port(1, 1'b1, 32'h80, 4'h3, 32'h2222_0000);
        drive();
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk); @(negedge clk); #1;
        n_vec++;
        if (all_out !== '0) begin
            n_err++; $display("FAIL reset_outputs: outputs=%h required 0", all_out);
        end
        @(negedge clk);
        rst = 1'b0;
        ptr_m = 0;
        run_txn(0, 0, $urandom);
        drain();
    endtask

    task automatic test_single_load();
        set_port(0, 1'b0, 32'h100, 4'hF, 32'h0);
        run_txn(0, 0, 32'hDEADBEEF);
    endtask

    task automatic test_alternate();
        set_random(0); set_random(1);
        for (int k = 0; k < 6; k++) begin
            run_txn($urandom_range(0, 2), $urandom_range(0, 2), $urandom);
            if (!req_m[0]) set_random(0);
            if (!req_m[1]) set_random(1);
        end
        drain();
    endtask

    task automatic test_dbg_store_delayed();
        set_port(1, 1'b1, 32'h2000, 4'b1100, 32'hCAFE_F00D);
        run_txn(4, 0, $urandom);
    endtask

    task automatic test_timeout();
        if (ptr_m != 0) begin
            set_random(1);
            run_txn(0, 0, $urandom);
        end
        set_random(0); set_random(1);
        run_txn(99, 0, $urandom);
        run_txn(0, 0, $urandom);
        set_random(0);
        run_txn(1, 20, $urandom);
    endtask

    task automatic test_reset_mid();
        if (ptr_m == 0) begin
            set_random(0);
            run_txn(0, 0, $urandom);
        end
        set_port(0, 1'b0, 32'h300, 4'hF, 32'h0);
        drive();
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk);
        mem_gnt = 1'b1; #1;
        n_vec++;
        if (lsu_gnt !== 1'b1) begin
            n_err++; $display("FAIL rstmid_gnt: lsu_gnt=%b required 1", lsu_gnt);
        end
        @(negedge clk);
        mem_gnt = 1'b0; req_m[0] = 1'b0; drive();
        #1;
        rst = 1'b1; #1;
        n_vec++;
        if (all_out !== '0) begin
            n_err++; $display("FAIL rstmid_outputs: outputs=%h required 0", all_out);
        end
        @(negedge clk);
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678; #1;
        n_vec++;
        if ({lsu_rvalid, lsu_err, busy, lsu_rdata} !== 35'h0) begin
            n_err++; $display("FAIL rstmid_late_rvalid: rvalid=%b err=%b busy=%b rdata=%h required 0",
                              lsu_rvalid, lsu_err, busy, lsu_rdata);
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
        ptr_m = 0;
        set_random(0); set_random(1);
        run_txn(0, 0, $urandom);
        drain();
    endtask

    task automatic test_random();
        int g, r;
        for (int k = 0; k < 40; k++) begin
            if (!req_m[0] && $urandom_range(0, 1) == 1) set_random(0);
            if (!req_m[1] && $urandom_range(0, 1) == 1) set_random(1);
            if (!req_m[0] && !req_m[1]) set_random(int'($urandom_range(0, 1)));
            g = ($urandom_range(0, 5) == 0) ? 9 : int'($urandom_range(0, 3));
            r = ($urandom_range(0, 5) == 0) ? 10 : int'($urandom_range(0, 3));
            run_txn(g, r, $urandom);
        end
        drain();
    endtask

    initial begin
        for (int p = 0; p < 2; p++) begin
            req_m[p] = 1'b0; we_m[p] = 1'b0; addr_m[p] = '0; be_m[p] = '0; wd_m[p] = '0;
        end
        drive();
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        test_reset();
        test_single_load();
        test_alternate();
        test_dbg_store_delayed();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
Shares the single data-memory port between two requesters: the load/store unit (port 0, "lsu") and the debug/DMA master (port 1, "dbg"). It runs one outstanding transaction at a time with round-robin fairness, a req/gnt/rvalid handshake on every side, and a watchdog that terminates a hung transaction with an error response. It sits between the MEM-stage load/store control and the memory macro/bus bridge.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; byte-enable width is DATA_W/8
TIMEOUT, 255, cycles allowed in REQ+RESP before error termination; 0 disables the watchdog

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
lsu_req  in  1  LSU request; held with its fields until lsu_gnt
lsu_we  in  1  1=store, 0=load
lsu_addr  in  ADDR_W  byte address
lsu_be  in  DATA_W/8  byte enables, passed through unmodified
lsu_wdata  in  DATA_W  store data, already lane-aligned
lsu_gnt  out  1  one-cycle pulse; memory accepted the LSU request
lsu_rvalid  out  1  one-cycle pulse; response (load data or store ack)
lsu_rdata  out  DATA_W  load data, valid with lsu_rvalid
lsu_err  out  1  qualifies lsu_rvalid; watchdog termination
dbg_req, dbg_we, dbg_addr, dbg_be, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err  same widths and meanings for port 1
mem_req  out  1  request to memory
mem_we  out  1  write strobe
mem_addr  out  ADDR_W  address
mem_be  out  DATA_W/8  byte enables
mem_wdata  out  DATA_W  write data
mem_gnt  in  1  memory accepts the request this cycle
mem_rvalid  in  1  memory response
mem_rdata  in  DATA_W  memory read data
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: clk/rst is one clock; reset is asynchronous and active-high. During reset state=IDLE, owner=0, priority pointer=lsu, watchdog=0, latched fields=0, and every output is 0. Asserting reset mid-transaction abandons that transaction: no gnt, rvalid or err is issued for it.
- FSM states: IDLE, REQ, RESP.
- IDLE, no requests: stay.
- IDLE, any request: select a winner, register owner, latch the winner's we/addr/be/wdata, clear the watchdog, and go to REQ. When both ports request, the priority pointer decides the winner.
- REQ: mem_req=1 and mem_* are driven from the latched fields (registered, no combinational path from requester inputs). If mem_gnt=1, pulse owner's gnt in the same cycle and go to RESP; otherwise hold.
- RESP: if mem_rvalid=1, drive owner's rvalid=1 and rdata=mem_rdata in the same cycle (combinational forward), err=0. Stores also receive rvalid as an ack. Flip the pointer to the non-owner and go to IDLE.
- Pointer: updates only on completion (rvalid or timeout), pointing to the other port. A lone requester is always served regardless of the pointer.
- Latency: minimum 3 cycles per transaction (IDLE, REQ with mem_gnt, RESP with mem_rvalid). Back-to-back throughput is 1 transaction per 3 cycles.
- Non-owner outputs: the non-owner's gnt, rvalid and err stay 0. Its rdata is 0 whenever its rvalid=0.
- Watchdog (TIMEOUT>0): counts every cycle spent in REQ or RESP and saturates at TIMEOUT. When it reaches TIMEOUT:
  - pulse owner rvalid=1, err=1, rdata=0 (also pulse gnt if still in REQ);
  - deassert mem_req and go to IDLE;
  - flip the pointer.
- Stray mem_rvalid: ignored in IDLE and REQ. The memory must not respond after a timeout; a late response is a system error and is not tracked.
- mem_gnt outside REQ: ignored.
- Requester protocol: the requester holds req and its fields stable until gnt. Dropping req before gnt is illegal; the latched transaction completes anyway.
- Simultaneous: owner completion and the other port's request in the same cycle returns to IDLE first; the new arbitration happens next cycle.

Test Plan:
- Reset: hold rst high with both reqs high -> all outputs 0, busy=0. Release -> LSU wins first, mem_addr=lsu_addr two cycles after release.
- Single LSU load at 0x100, mem_gnt immediate, mem_rvalid next cycle with 0xDEADBEEF -> lsu_gnt at cycle 2, lsu_rvalid with rdata 0xDEADBEEF at cycle 3, lsu_err=0.
- Both ports continuously requesting -> grants alternate lsu, dbg, lsu, dbg; each port's mem_we/addr/be/wdata appear on mem_* only during its own REQ.
- dbg store be=0b1100, mem_gnt delayed 4 cycles -> mem_req held 5 cycles with stable fields, dbg_gnt single pulse, dbg_rvalid ack with err=0.
- TIMEOUT=8, mem_gnt never asserted -> lsu_gnt, lsu_rvalid and lsu_err pulse together 8 cycles after REQ entry; mem_req drops; the next pending dbg request is served.
- Reset asserted in RESP, then mem_rvalid pulses -> no lsu_rvalid, state IDLE, pointer=lsu.
